// File: rtl/pong_ball_engine.sv
// pong_ball_engine: game-logic stage feeding the renderer. Owns the ball
// position and direction, wall/paddle collision, scoring and the
// serve / game-over sequencing.
// Optional feature macro: BALL_SPEEDUP_EN (each paddle return speeds the ball up).
//
// state     | meaning
// INITIAL   | idle, ball parked at centre, waiting for start
// SERVE     | ball parked at centre, counting serve ticks
// MOVE      | ball steps once per tick on both axes
// CHECK     | one cycle: wall reflection and paddle hit/miss test
// SCORE     | one cycle: credit the scorer, re-centre the ball
// GAMEOVER  | scores frozen, banner offset advances per tick

module pong_ball_engine #(
    parameter int SPEED       = 2,
    parameter int MAX_SPEED   = 6,
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_TICKS = 32,
    parameter int TEXT_MAX    = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       ack,
    input  logic [9:0] p_1,
    input  logic [9:0] p_2,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [3:0] player_1_score,
    output logic [3:0] player_2_score,
    output logic [9:0] text_offset,
    output logic       q_INITIAL,
    output logic       q_SERVE,
    output logic       q_MOVE,
    output logic       q_CHECK,
    output logic       q_SCORE,
    output logic       q_GAMEOVER
);

    localparam logic [9:0]  X_CENTRE  = 10'd320;
    localparam logic [9:0]  Y_CENTRE  = 10'd240;
    localparam logic [9:0]  X_LEFT    = 10'd19;
    localparam logic [9:0]  X_RIGHT   = 10'd621;
    localparam logic [9:0]  Y_TOP     = 10'd3;
    localparam logic [9:0]  Y_BOTTOM  = 10'd476;
    // paddle half-height plus ball radius
    localparam logic [10:0] PAD_REACH = 11'd43;
    localparam logic [10:0] Y_LAST    = 11'd479;

    localparam int SPD_W = $clog2(MAX_SPEED + 1);
    localparam int CNT_W = $clog2(SERVE_TICKS) + 1;

    localparam logic [SPD_W-1:0] SPD_INIT  = SPD_W'(SPEED);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SERVE_TICKS - 1);
    localparam logic [3:0]       SCORE_WIN = 4'(WIN_SCORE);
    localparam logic [9:0]       TEXT_LAST = 10'(TEXT_MAX);

    typedef enum logic [2:0] {
        S_INITIAL,
        S_SERVE,
        S_MOVE,
        S_CHECK,
        S_SCORE,
        S_GAMEOVER
    } state_t;

    state_t           state_q, state_nxt;
    logic [9:0]       x_q, x_nxt;
    logic [9:0]       y_q, y_nxt;
    logic             dir_x_q, dir_x_nxt;   // 1 = moving right
    logic             dir_y_q, dir_y_nxt;   // 1 = moving down
    logic [SPD_W-1:0] speed_q, speed_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [3:0]       s1_q, s1_nxt;
    logic [3:0]       s2_q, s2_nxt;
    logic [9:0]       text_q, text_nxt;
    logic             scorer_q, scorer_nxt; // 1 = player 2 scored

    logic [9:0]       step;
    logic [3:0]       s1_inc, s2_inc;
    logic             hit_1, hit_2;
    logic [SPD_W-1:0] speed_ret;

    // Paddle window with both bounds clamped to the field.
    function automatic logic in_window(input logic [9:0] paddle, input logic [9:0] ball_y);
        logic [10:0] lo;
        logic [10:0] hi;
        lo = ({1'b0, paddle} > PAD_REACH) ? {1'b0, paddle} - PAD_REACH : 11'd0;
        hi = ({1'b0, paddle} + PAD_REACH > Y_LAST) ? Y_LAST : {1'b0, paddle} + PAD_REACH;
        return ({1'b0, ball_y} >= lo) && ({1'b0, ball_y} <= hi);
    endfunction

    assign step   = 10'(speed_q);
    assign hit_1  = in_window(p_1, y_q);
    assign hit_2  = in_window(p_2, y_q);
    assign s1_inc = (s1_q == 4'd15) ? s1_q : s1_q + 4'd1;
    assign s2_inc = (s2_q == 4'd15) ? s2_q : s2_q + 4'd1;

`ifdef BALL_SPEEDUP_EN
    localparam logic [SPD_W-1:0] SPD_MAX = SPD_W'(MAX_SPEED);
    assign speed_ret = (speed_q < SPD_MAX) ? speed_q + SPD_W'(1) : speed_q;
`else
    assign speed_ret = SPD_INIT;
`endif

    // Next-state and datapath decisions for the whole game sequence.
    always_comb begin
        state_nxt  = state_q;
        x_nxt      = x_q;
        y_nxt      = y_q;
        dir_x_nxt  = dir_x_q;
        dir_y_nxt  = dir_y_q;
        speed_nxt  = speed_q;
        cnt_nxt    = cnt_q;
        s1_nxt     = s1_q;
        s2_nxt     = s2_q;
        text_nxt   = 10'd0;
        scorer_nxt = scorer_q;

        case (state_q)
            S_INITIAL: begin
                x_nxt = X_CENTRE;
                y_nxt = Y_CENTRE;
                if (start) begin
                    state_nxt = S_SERVE;
                    cnt_nxt   = '0;
                    dir_x_nxt = 1'b1;
                end
            end
            S_SERVE: begin
                x_nxt = X_CENTRE;
                y_nxt = Y_CENTRE;
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_nxt = S_MOVE;
                        cnt_nxt   = '0;
                        dir_y_nxt = ~dir_y_q;
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_MOVE: begin
                if (tick) begin
                    if (dir_x_q)
                        x_nxt = (x_q < X_RIGHT - step) ? x_q + step : X_RIGHT;
                    else
                        x_nxt = (x_q > X_LEFT + step) ? x_q - step : X_LEFT;
                    if (dir_y_q)
                        y_nxt = (y_q < Y_BOTTOM - step) ? y_q + step : Y_BOTTOM;
                    else
                        y_nxt = (y_q > Y_TOP + step) ? y_q - step : Y_TOP;
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                state_nxt = S_MOVE;
                if (y_q == Y_TOP)
                    dir_y_nxt = 1'b1;
                if (y_q == Y_BOTTOM)
                    dir_y_nxt = 1'b0;
                if (x_q == X_LEFT && !dir_x_q) begin
                    if (hit_1) begin
                        dir_x_nxt = 1'b1;
                        speed_nxt = speed_ret;
                    end else begin
                        state_nxt  = S_SCORE;
                        scorer_nxt = 1'b1;
                    end
                end else if (x_q == X_RIGHT && dir_x_q) begin
                    if (hit_2) begin
                        dir_x_nxt = 1'b0;
                        speed_nxt = speed_ret;
                    end else begin
                        state_nxt  = S_SCORE;
                        scorer_nxt = 1'b0;
                    end
                end
            end
            S_SCORE: begin
                x_nxt     = X_CENTRE;
                y_nxt     = Y_CENTRE;
                cnt_nxt   = '0;
                speed_nxt = SPD_INIT;
                // the next serve heads toward whoever conceded
                if (scorer_q) begin
                    s2_nxt    = s2_inc;
                    dir_x_nxt = 1'b0;
                    state_nxt = (s2_inc == SCORE_WIN) ? S_GAMEOVER : S_SERVE;
                end else begin
                    s1_nxt    = s1_inc;
                    dir_x_nxt = 1'b1;
                    state_nxt = (s1_inc == SCORE_WIN) ? S_GAMEOVER : S_SERVE;
                end
            end
            S_GAMEOVER: begin
                x_nxt    = X_CENTRE;
                y_nxt    = Y_CENTRE;
                text_nxt = text_q;
                if (tick)
                    text_nxt = (text_q == TEXT_LAST) ? 10'd0 : text_q + 10'd1;
            end
            default: begin
                state_nxt = S_INITIAL;
            end
        endcase
    end

    // Register update; reset and an abandoning ack both restore power-up values.
    always_ff @(posedge clk) begin
        if (reset || (ack && state_q != S_INITIAL)) begin
            state_q  <= S_INITIAL;
            x_q      <= X_CENTRE;
            y_q      <= Y_CENTRE;
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
            speed_q  <= SPD_INIT;
            cnt_q    <= '0;
            s1_q     <= 4'd0;
            s2_q     <= 4'd0;
            text_q   <= 10'd0;
            scorer_q <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            x_q      <= x_nxt;
            y_q      <= y_nxt;
            dir_x_q  <= dir_x_nxt;
            dir_y_q  <= dir_y_nxt;
            speed_q  <= speed_nxt;
            cnt_q    <= cnt_nxt;
            s1_q     <= s1_nxt;
            s2_q     <= s2_nxt;
            text_q   <= text_nxt;
            scorer_q <= scorer_nxt;
        end
    end

    assign x              = x_q;
    assign y              = y_q;
    assign player_1_score = s1_q;
    assign player_2_score = s2_q;
    assign text_offset    = text_q;
    assign q_INITIAL      = (state_q == S_INITIAL);
    assign q_SERVE        = (state_q == S_SERVE);
    assign q_MOVE         = (state_q == S_MOVE);
    assign q_CHECK        = (state_q == S_CHECK);
    assign q_SCORE        = (state_q == S_SCORE);
    assign q_GAMEOVER     = (state_q == S_GAMEOVER);

endmodule
